vga_rx: RTL

VGA_RX -- requirements
Module: vga_rx

---
 rtl/vga_rx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/vga_rx.sv
// VGA timing receiver: acquires lock on incoming Hs/Vs timing and emits active-area
// pixels with coordinates. Two register stages from input pins to output ports.
module vga_rx #(
    parameter int H_SYNC_CYC     = 96,
    parameter int H_BACK_PORCH   = 48,
    parameter int H_ACTIVE_VIDEO = 640,
    parameter int H_LINE         = 800,
    parameter int V_SYNC_CYC     = 2,
    parameter int V_BACK_PORCH   = 33,
    parameter int V_ACTIVE_VIDEO = 480,
    parameter int V_LINE         = 525
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vgaHs,
    input  logic       vgaVs,
    input  logic [2:0] vgaR,
    input  logic [2:0] vgaG,
    input  logic [2:0] vgaB,
    output logic       pixelValid,
    output logic [9:0] pixelX,
    output logic [9:0] pixelY,
    output logic [2:0] pixelR,
    output logic [2:0] pixelG,
    output logic [2:0] pixelB,
    output logic       frameStart,
    output logic       locked,
    output logic [7:0] errCount
);

    localparam logic [9:0]  H_LAST  = 10'(H_LINE - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_LINE - 1);
    localparam logic [9:0]  CNT_MAX = 10'h3FF;
    localparam logic [10:0] H_START = 11'(H_SYNC_CYC + H_BACK_PORCH);
    localparam logic [10:0] H_END   = 11'(H_SYNC_CYC + H_BACK_PORCH + H_ACTIVE_VIDEO);
    localparam logic [10:0] V_START = 11'(V_SYNC_CYC + V_BACK_PORCH);
    localparam logic [10:0] V_END   = 11'(V_SYNC_CYC + V_BACK_PORCH + V_ACTIVE_VIDEO);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       confirmed, confirmed_nxt;
    logic       lock_lost;

    logic       hs1, vs1, hs_prev, vs_line;
    logic [2:0] r1, g1, b1;
    logic [9:0] h_cnt, v_cnt, h_cur, v_cur;
    logic       line_start, frame_start, bad_line, bad_frame, active;

    // stage 1: input capture
    always_ff @(posedge clk) begin
        if (rst) begin
            hs1     <= 1'b1;
            vs1     <= 1'b1;
            hs_prev <= 1'b1;
            r1      <= '0;
            g1      <= '0;
            b1      <= '0;
        end else begin
            hs1     <= vgaHs;
            vs1     <= vgaVs;
            hs_prev <= hs1;
            r1      <= vgaR;
            g1      <= vgaG;
            b1      <= vgaB;
        end
    end

    assign line_start  = hs_prev & ~hs1;
    assign frame_start = line_start & ~vs1 & vs_line;
    assign bad_line    = line_start & (h_cnt != H_LAST);
    assign bad_frame   = frame_start & (v_cnt != V_LAST);

    // h_cur/v_cur are the coordinates of the pixel currently in stage 1
    always_comb begin
        h_cur = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 10'd1;
        if (line_start)
            h_cur = '0;
        v_cur = v_cnt;
        if (frame_start)
            v_cur = '0;
        else if (line_start && v_cnt != CNT_MAX)
            v_cur = v_cnt + 10'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            vs_line <= 1'b1;
        end else begin
            h_cnt <= h_cur;
            v_cnt <= v_cur;
            if (line_start)
                vs_line <= vs1;
        end
    end

    // A bad line is applied first so a coincident frame start restarts acquisition.
    always_comb begin
        state_nxt     = state;
        confirmed_nxt = confirmed;
        lock_lost     = 1'b0;
        if (bad_line) begin
            lock_lost     = (state == LOCKED);
            state_nxt     = SEARCH;
            confirmed_nxt = 1'b0;
        end
        if (frame_start) begin
            case (state_nxt)
                SEARCH: begin
                    state_nxt     = TRACK;
                    confirmed_nxt = 1'b0;
                end
                TRACK: begin
                    if (bad_frame) begin
                        state_nxt     = SEARCH;
                        confirmed_nxt = 1'b0;
                    end else if (confirmed_nxt) begin
                        state_nxt     = LOCKED;
                        confirmed_nxt = 1'b0;
                    end else begin
                        confirmed_nxt = 1'b1;
                    end
                end
                LOCKED: begin
                    if (bad_frame) begin
                        state_nxt = SEARCH;
                        lock_lost = 1'b1;
                    end
                end
                default: begin
                    state_nxt     = SEARCH;
                    confirmed_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEARCH;
            confirmed <= 1'b0;
        end else begin
            state     <= state_nxt;
            confirmed <= confirmed_nxt;
        end
    end

    assign active = (state == LOCKED)
                 && ({1'b0, h_cur} >= H_START) && ({1'b0, h_cur} < H_END)
                 && ({1'b0, v_cur} >= V_START) && ({1'b0, v_cur} < V_END);

    // stage 2: output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pixelValid <= 1'b0;
            pixelX     <= '0;
            pixelY     <= '0;
            pixelR     <= '0;
            pixelG     <= '0;
            pixelB     <= '0;
            frameStart <= 1'b0;
            locked     <= 1'b0;
            errCount   <= '0;
        end else begin
            pixelValid <= active;
            frameStart <= frame_start;
            locked     <= (state_nxt == LOCKED);
            if (active) begin
                pixelX <= h_cur - H_START[9:0];
                pixelY <= v_cur - V_START[9:0];
                pixelR <= r1;
                pixelG <= g1;
                pixelB <= b1;
            end else begin
                pixelR <= '0;
                pixelG <= '0;
                pixelB <= '0;
            end
            if (lock_lost && errCount != 8'hFF)
                errCount <= errCount + 8'd1;
        end
    end

endmodule
